// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory; illegal accesses are rejected with ack+err.
// Optional build macro DMEM_ARB_LOCK_EN adds pN_lock inputs and the HOLD state for locked access sequences.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [1:0]        p0_lwhb,
  input  logic [1:0]        p0_swhb,
  input  logic              p0_lu,
  input  logic [ADDR_W-1:0] p0_pc,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [1:0]        p1_lwhb,
  input  logic [1:0]        p1_swhb,
  input  logic              p1_lu,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              p0_lock,
  input  logic              p1_lock,
`endif
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  output logic              p0_stall,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic [1:0]        mem_lwhb,
  output logic [1:0]        mem_swhb,
  output logic              mem_lu,
  output logic [ADDR_W-1:0] mem_pc,
  input  logic [31:0]       mem_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam int unsigned EXT_W = ADDR_W + 1;

  logic [1:0]        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last, w_last_nxt;

  logic              w_we, w_lu, w_lock, w_own_req, w_illegal, w_busy;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_rdata;
  logic [1:0]        w_lwhb, w_swhb, w_size, w_cand;
  logic [2:0]        w_bytes;
  logic [EXT_W-1:0]  w_end;

  // Owner's request fields
  assign w_we      = r_owner ? p1_we    : p0_we;
  assign w_addr    = r_owner ? p1_addr  : p0_addr;
  assign w_wdata   = r_owner ? p1_wdata : p0_wdata;
  assign w_lwhb    = r_owner ? p1_lwhb  : p0_lwhb;
  assign w_swhb    = r_owner ? p1_swhb  : p0_swhb;
  assign w_lu      = r_owner ? p1_lu    : p0_lu;
  assign w_own_req = r_owner ? p1_req   : p0_req;
`ifdef DMEM_ARB_LOCK_EN
  assign w_lock    = r_owner ? p1_lock  : p0_lock;
`else
  assign w_lock    = 1'b0;
`endif
  assign w_busy    = (r_state == ST_BUSY);

  // Legality: size code, alignment, and last touched byte inside memory
  always_comb begin
    w_size  = w_we ? w_swhb : w_lwhb;
    w_bytes = 3'd0;
    case (w_size)
      2'b11:   w_bytes = 3'd4;
      2'b10:   w_bytes = 3'd2;
      2'b01:   w_bytes = 3'd1;
      default: w_bytes = 3'd0;
    endcase
    w_end     = EXT_W'(w_addr) + EXT_W'(w_bytes) - EXT_W'(1);
    w_illegal = (w_size == 2'b00)
              | ((w_size == 2'b11) & (w_addr[1:0] != 2'b00))
              | ((w_size == 2'b10) & w_addr[0])
              | (w_end >= EXT_W'(MEM_BYTES));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= ~1'(RESET_PRIO);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state; the port served in BUSY has its still-high req treated as consumed
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cand      = {p1_req, p0_req};
    if (w_busy) w_cand[r_owner] = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (w_own_req) begin
          w_state_nxt = ST_BUSY;
          w_last_nxt  = r_owner;
        end
      end
      default: begin
        if (w_busy && w_lock) begin
          w_state_nxt = ST_HOLD;
        end else if (w_cand == 2'b11) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = ~r_last;
          w_last_nxt  = ~r_last;
        end else if (w_cand[0]) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end else if (w_cand[1]) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = 1'b1;
          w_last_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Memory port and responses, live only while BUSY
  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    mem_lwhb = 2'b00;
    mem_swhb = 2'b00;
    mem_lu   = 1'b0;
    mem_pc   = '0;
    p0_ack   = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ack   = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    w_rdata  = (w_we | w_illegal) ? 32'd0 : mem_rd;
    if (w_busy) begin
      mem_we   = w_we & ~w_illegal;
      mem_a    = w_addr;
      mem_wd   = w_wdata;
      mem_lwhb = w_illegal ? 2'b00 : w_lwhb;
      mem_swhb = w_illegal ? 2'b00 : w_swhb;
      mem_lu   = w_lu;
      mem_pc   = r_owner ? '0 : p0_pc;
      if (r_owner) begin
        p1_ack   = 1'b1;
        p1_err   = w_illegal;
        p1_rdata = w_rdata;
      end else begin
        p0_ack   = 1'b1;
        p0_err   = w_illegal;
        p0_rdata = w_rdata;
      end
    end
  end

  assign p0_stall = p0_req & ~(w_busy & ~r_owner);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model; lock steps build only with DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_req, p0_we, p0_lu, p1_req, p1_we, p1_lu;
  logic [31:0] p0_addr, p0_wdata, p0_pc, p1_addr, p1_wdata;
  logic [1:0]  p0_lwhb, p0_swhb, p1_lwhb, p1_swhb;
`ifdef DMEM_ARB_LOCK_EN
  logic        p0_lock, p1_lock;
`endif
  logic        p0_ack, p0_err, p0_stall, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_lu;
  logic [31:0] mem_a, mem_wd, mem_pc, mem_rd;
  logic [1:0]  mem_lwhb, mem_swhb;

  logic [7:0]  tb_mem [4096];
  logic        mem_clr;
  logic [11:0] ra, wa;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(4096), .RESET_PRIO(0)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lwhb(p0_lwhb), .p0_swhb(p0_swhb), .p0_lu(p0_lu), .p0_pc(p0_pc),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lwhb(p1_lwhb), .p1_swhb(p1_swhb), .p1_lu(p1_lu),
`ifdef DMEM_ARB_LOCK_EN
    .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_lwhb(mem_lwhb),
    .mem_swhb(mem_swhb), .mem_lu(mem_lu), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  // Memory model: combinational sized read, garbage for size 00 so masking is visible
  always_comb begin
    ra = mem_a[11:0];
    case (mem_lwhb)
      2'b11:   mem_rd = {tb_mem[ra + 12'd3], tb_mem[ra + 12'd2], tb_mem[ra + 12'd1], tb_mem[ra]};
      2'b10:   mem_rd = {{16{~mem_lu & tb_mem[ra + 12'd1][7]}}, tb_mem[ra + 12'd1], tb_mem[ra]};
      2'b01:   mem_rd = {{24{~mem_lu & tb_mem[ra][7]}}, tb_mem[ra]};
      default: mem_rd = 32'hA5A5_A5A5;
    endcase
  end

  assign wa = mem_a[11:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 8'h00;
    end else if (mem_we) begin
      case (mem_swhb)
        2'b11: begin
          tb_mem[wa] <= mem_wd[7:0];            tb_mem[wa + 12'd1] <= mem_wd[15:8];
          tb_mem[wa + 12'd2] <= mem_wd[23:16];  tb_mem[wa + 12'd3] <= mem_wd[31:24];
        end
        2'b10: begin
          tb_mem[wa] <= mem_wd[7:0];            tb_mem[wa + 12'd1] <= mem_wd[15:8];
        end
        2'b01:   tb_mem[wa] <= mem_wd[7:0];
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] mword(input logic [11:0] a);
    return {tb_mem[a + 12'd3], tb_mem[a + 12'd2], tb_mem[a + 12'd1], tb_mem[a]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] lwhb, input logic [1:0] swhb, input logic lu);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    p0_lwhb = lwhb; p0_swhb = swhb; p0_lu = lu;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] lwhb, input logic [1:0] swhb, input logic lu);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    p1_lwhb = lwhb; p1_swhb = swhb; p1_lu = lu;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; mem_clr = 1'b1; p0_pc = 32'h0000_0100;
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
`ifdef DMEM_ARB_LOCK_EN
    p0_lock = 1'b0; p1_lock = 1'b0;
`endif
    tick(); tick();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_acks", {30'd0, p1_ack, p0_ack}, 0);
    mem_clr = 1'b0;
    rstn = 1'b1;

    // p0 store word, then load it back
    drv0(1, 1, 32'h10, 32'hDEAD_BEEF, 2'b00, 2'b11, 0);
    #1 chk("st_stall_pre", 32'(p0_stall), 1);
    tick();
    chk("st_ack", {30'd0, p0_ack, p0_err}, 32'h2);
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_mem_a", mem_a, 32'h10);
    chk("st_mem_pc", mem_pc, 32'h100);
    chk("st_stall", 32'(p0_stall), 0);
    tick();
    chk("st_one_cycle", {30'd0, mem_we, p0_ack}, 0);
    chk("st_mem", mword(12'h10), 32'hDEAD_BEEF);
    drv0(1, 0, 32'h10, 0, 2'b11, 2'b00, 0);
    tick();
    chk("ld_ack", {30'd0, p0_ack, p0_err}, 32'h2);
    chk("ld_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Simultaneous requests after reset: p0 first, then strict alternation
    do_reset();
    drv0(1, 0, 32'h10, 0, 2'b11, 2'b00, 0);
    drv1(1, 0, 32'h14, 0, 2'b11, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_p0_ack", 32'(p0_ack), 32'((i % 2) == 0));
      chk("alt_p1_ack", 32'(p1_ack), 32'((i % 2) == 1));
    end
    chk("alt_p0_stall", 32'(p0_stall), 1);
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    chk("alt_idle", {30'd0, p1_ack, p0_ack}, 0);

    // Half store from p1, signed and unsigned half loads from p0
    drv1(1, 1, 32'h22, 32'h0000_8123, 2'b00, 2'b10, 0);
    tick();
    chk("sh_ack", {30'd0, p1_ack, mem_we}, 32'h3);
    chk("sh_swhb", 32'(mem_swhb), 32'h2);
    chk("sh_mem_pc", mem_pc, 0);
    tick();
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
    drv0(1, 0, 32'h22, 0, 2'b10, 2'b00, 0);
    tick();
    chk("lh_signed", p0_rdata, 32'hFFFF_8123);
    tick();
    drv0(1, 0, 32'h22, 0, 2'b10, 2'b00, 1);
    tick();
    chk("lhu", p0_rdata, 32'h0000_8123);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Illegal accesses: misaligned word, out-of-range byte, size 00; legal top word
    drv0(1, 0, 32'h6, 0, 2'b11, 2'b00, 0);
    tick();
    chk("mis_ack_err", {30'd0, p0_ack, p0_err}, 32'h3);
    chk("mis_rdata", p0_rdata, 0);
    chk("mis_lwhb", 32'(mem_lwhb), 0);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);
    drv1(1, 1, 32'h1000, 32'h77, 2'b00, 2'b01, 0);
    tick();
    chk("oob_ack_err", {30'd0, p1_ack, p1_err}, 32'h3);
    chk("oob_mem_we", 32'(mem_we), 0);
    tick();
    chk("oob_mem0", 32'(tb_mem[0]), 0);
    drv1(1, 0, 32'hFFC, 0, 2'b11, 2'b00, 0);
    tick();
    chk("top_word_err", {30'd0, p1_ack, p1_err}, 32'h2);
    tick();
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
    drv0(1, 1, 32'h30, 32'h5555_5555, 2'b00, 2'b00, 0);
    tick();
    chk("sz0_ack_err", {30'd0, p0_ack, p0_err}, 32'h3);
    chk("sz0_mem_we", 32'(mem_we), 0);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);
    chk("sz0_mem", mword(12'h30), 0);

    // Reset asserted in the middle of a p1 store
    drv1(1, 1, 32'h40, 32'h1234_5678, 2'b00, 2'b11, 0);
    tick();
    chk("rmid_pre_we", 32'(mem_we), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rmid_we", 32'(mem_we), 0);
    chk("rmid_ack", 32'(p1_ack), 0);
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rmid_mem", mword(12'h40), 0);
    chk("rmid_idle", mem_a, 0);
    drv0(1, 0, 32'h40, 0, 2'b11, 2'b00, 0);
    tick();
    chk("rmid_after_ack", {30'd0, p0_ack, p0_err}, 32'h2);
    chk("rmid_after_rd", p0_rdata, 0);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);

`ifdef DMEM_ARB_LOCK_EN
    // p1 locks through three stores while p0 waits
    do_reset();
    drv1(1, 1, 32'h50, 32'h1, 2'b00, 2'b11, 0);
    p1_lock = 1'b1;
    tick();
    chk("lk_a1", {30'd0, p1_ack, p0_ack}, 32'h2);
    drv0(1, 0, 32'h50, 0, 2'b11, 2'b00, 0);
    #1 chk("lk_stall0", 32'(p0_stall), 1);
    tick();
    chk("lk_hold1", {30'd0, p1_ack, p0_ack}, 0);
    tick();
    chk("lk_a2", {30'd0, p1_ack, p0_ack}, 32'h2);
    tick();
    chk("lk_hold2", {30'd0, p1_ack, p0_ack}, 0);
    chk("lk_stall2", 32'(p0_stall), 1);
    p1_lock = 1'b0;
    tick();
    chk("lk_a3", {30'd0, p1_ack, p0_ack}, 32'h2);
    chk("lk_stall3", 32'(p0_stall), 1);
    drv1(0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    chk("lk_p0", {30'd0, p1_ack, p0_ack}, 32'h1);
    chk("lk_p0_rd", p0_rdata, 32'h1);
    tick();
    drv0(0, 0, 0, 0, 2'b00, 2'b00, 0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the byte-addressable data memory.
- Port 0 is the CPU load/store unit. Port 1 is a loader/debug master that writes programs or data and inspects memory.
- Grants one access per cycle to the memory's single combinational-read / posedge-write port, using round-robin fairness.
- Rejects illegal accesses (bad size, misaligned, out of range) with an error response; such accesses never reach memory.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- MEM_BYTES, 4096, memory size in bytes; any access touching an address >= MEM_BYTES is an error.
- RESET_PRIO, 0, port that wins the first two-way contention after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- pN_req  in  1  request from port N (N=0,1); held high with stable fields until pN_ack.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  ADDR_W  byte address.
- pN_wdata  in  32  store data, in low bytes for half/byte stores.
- pN_lwhb  in  2  load size: 11 word, 10 half, 01 byte, 00 illegal.
- pN_swhb  in  2  store size, same encoding.
- pN_lu  in  1  load unsigned.
- p0_pc  in  ADDR_W  CPU pc, forwarded to memory for the store trace.
- pN_ack  out  1  one-cycle completion pulse.
- pN_err  out  1  valid with ack; access rejected.
- pN_rdata  out  32  load data, valid with ack.
- p0_stall  out  1  p0_req & ~p0_ack.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDR_W  memory address.
- mem_wd  out  32  memory write data.
- mem_lwhb, mem_swhb  out  2  size codes to memory.
- mem_lu  out  1  unsigned-load flag.
- mem_pc  out  ADDR_W  p0_pc when port 0 owns the access, else 0.
- mem_rd  in  32  combinational memory read data.

Behaviour:
- Reset (async, immediate):
  - State IDLE; owner=0; last-served = ~RESET_PRIO.
  - All ack/err/rdata/stall-independent outputs and all mem_* outputs = 0.
  - mem_we drops the moment rstn falls, including mid-access; an interrupted store is not committed.
- States:
  - IDLE: no owner.
  - BUSY: owner registered; access performed this cycle.
  - HOLD: only exists with the optional feature.
- Arbitration at each posedge in IDLE or at the end of BUSY:
  - Candidates are ports with req=1, excluding the port just served in BUSY. Its req is still high at that edge and counts as consumed.
  - One candidate: grant it. Two candidates: grant the port not last served.
  - Any grant -> BUSY with owner=winner, last-served=winner. No candidates -> IDLE.
- BUSY cycle:
  - mem_a/wd/lwhb/swhb/lu are driven combinationally from the owner's inputs.
  - pOwner_ack=1 and pOwner_rdata=mem_rd for loads, 0 for stores.
  - mem_we = owner_we & ~illegal; the store commits at the edge ending BUSY.
- Latency and throughput:
  - Request first seen at edge k -> ack in cycle k+1.
  - A single port gets at most one access every 2 cycles.
  - Two alternating ports get 1 access per cycle.
- A requester may re-raise req in the cycle after ack; it is sampled as a new request.
- Illegal access, size code taken from swhb if we else lwhb:
  - size code 00; or
  - word with addr[1:0]!=0, or half with addr[0]!=0; or
  - addr + bytes - 1 >= MEM_BYTES.
  - Response: ack=1, err=1, rdata=0, mem_we=0, mem_lwhb=mem_swhb=0. Same 1-cycle timing as a legal access.
- Non-owner outputs: ack=0, err=0, rdata=0.
- IDLE: all mem_* outputs = 0.
- A req dropped before ack is protocol violation; behaviour undefined, no assertion required.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro:
  - Adds input pN_lock (1 bit), sampled with the owner's request.
  - If the owner's lock=1 at the edge ending BUSY, go to HOLD: only that port may be granted; the other port waits.
  - HOLD -> BUSY on the locked port's next req.
  - Lock releases after an access completes with lock=0.
  - Reset clears HOLD.
- Without the macro: no lock ports; HOLD unreachable; pure round-robin.

Test Plan:
- Reset, then p0 store word 0xDEADBEEF @0x10 -> ack cycle 2, err=0, mem_we=1 one cycle; p0 load word @0x10 -> rdata=0xDEADBEEF.
- p0 and p1 raise req at the same edge after reset (RESET_PRIO=0), both held through their ack cycles and re-raised immediately after -> grants alternate p0,p1,p0,p1, one ack per cycle, no port granted twice in a row.
- p1 store half 0x8123 @0x22, then p0 load half signed @0x22 -> 0xFFFF8123; with lu=1 -> 0x00008123.
- p0 load word @0x0000_0006 -> ack+err, rdata=0, mem_we=0. p1 store byte @0x1000 (MEM_BYTES=4096) -> ack+err, memory unchanged. swhb=00 store -> err.
- rstn pulled low mid-BUSY of a p1 store @0x40 -> mem_we and ack fall immediately, @0x40 unchanged, state IDLE after release.
- DMEM_ARB_LOCK_EN: p1 issues 3 stores with lock=1,1,0 while p0 requests continuously -> p0 ack only after the third p1 ack; p0_stall high throughout.
